// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/halt/single-step controller for the 6502 CPU clock.
// Drives the clock divider enable, sequences the CPU reset line, and
// synchronises/debounces the raw run and step push-buttons.

// Button front end: 2-flop synchroniser, counter debouncer, rising-edge pulse.
module cpu_clk_ctrl_debounce #(
  parameter int CYCLES = 12000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Accept a new level only after it has been stable for CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign press = level & ~level_q;

endmodule

module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int RESET_HOLD      = 16,
  parameter int STEP_CYCLES     = 2,
  parameter int START_RUN       = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_run,
  input  logic btn_step,
  input  logic ext_halt,
  output logic div_enable,
  output logic cpu_reset_n,
  output logic running,
  output logic step_busy
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic START_IN_RUN = (START_RUN != 0);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_HALT,
    ST_STEP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              hold_done;
  logic              step_done;
  logic              run_press;
  logic              step_press;

  cpu_clk_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_run),
    .press   (run_press)
  );

  cpu_clk_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_step),
    .press   (step_press)
  );

  assign hold_done = (hold_cnt == HOLD_LAST);
  assign step_done = (step_cnt == STEP_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Reset-hold and step-length counters; each clears whenever its state is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      step_cnt <= '0;
    end else begin
      if (state == ST_RESET && !hold_done) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (state == ST_STEP && !step_done) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end else begin
        step_cnt <= '0;
      end
    end
  end

  // Next-state logic and Moore output decode from the state register.
  always_comb begin
    state_next  = state;
    div_enable  = 1'b0;
    cpu_reset_n = 1'b1;
    running     = 1'b0;
    step_busy   = 1'b0;
    case (state)
      ST_RESET: begin
        div_enable  = 1'b1;
        cpu_reset_n = 1'b0;
        if (hold_done) begin
          if (START_IN_RUN && !ext_halt) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_HALT;
          end
        end
      end
      ST_RUN: begin
        div_enable = 1'b1;
        running    = 1'b1;
        if (run_press || ext_halt) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (run_press && !ext_halt) begin
          state_next = ST_RUN;
        end else if (step_press) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        div_enable = 1'b1;
        step_busy  = 1'b1;
        if (step_done) begin
          state_next = ST_HALT;
        end
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

endmodule
